// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_REQ = 16;

  // Width of an index/counter field; never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, found via a double-width masked priority search.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int p_num_req = 4
) (
  input  logic [p_num_req-1:0]             req,
  input  logic [clog2_min1(p_num_req)-1:0] ptr,
  output logic                             found,
  output logic [clog2_min1(p_num_req)-1:0] idx
);

  localparam int ID_W = clog2_min1(p_num_req);

  logic [p_num_req-1:0]   mask;
  logic [2*p_num_req-1:0] dbl;
  int                     pos;

  // Low half holds requests at/above ptr, high half the full vector, so the
  // lowest set bit of the pair is the wrap-around winner.
  always_comb begin
    mask  = ~((p_num_req'(1) << ptr) - p_num_req'(1));
    dbl   = {req, req & mask};
    found = |req;
    pos   = 0;
    for (int i = 2*p_num_req-1; i >= 0; i--) begin
      if (dbl[i]) pos = i;
    end
    idx = ID_W'((pos >= p_num_req) ? pos - p_num_req : pos);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: locks one requester per burst and muxes its
// valid/data onto the shared channel; only the grantee sees ready.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int p_width     = 32,
  parameter int p_num_req   = 4,
  parameter int p_max_burst = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [p_num_req-1:0]              i_valid,
  input  logic [p_num_req-1:0][p_width-1:0] i_data,
  input  logic [p_num_req-1:0]              i_last,
  output logic [p_num_req-1:0]              o_ready,
  output logic                              o_valid,
  output logic [p_width-1:0]                o_data,
  input  logic                              i_ready,
  output logic [p_num_req-1:0]              o_grant,
  output logic [clog2_min1(p_num_req)-1:0]  o_grant_id
);

  localparam int ID_W  = clog2_min1(p_num_req);
  localparam int CNT_W = clog2_min1(p_max_burst + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(p_max_burst - 1);

  arb_state_e           state_q;
  logic [ID_W-1:0]      gnt_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [CNT_W-1:0]     beat_cnt_q;
  logic [p_num_req-1:0] grant_q;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            in_burst;
  logic            accept;
  logic            burst_end;
  logic [ID_W-1:0] next_ptr;

  rr_picker #(
    .p_num_req(p_num_req)
  ) u_picker (
    .req  (i_valid),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign in_burst  = (state_q == BURST);
  assign accept    = o_valid & i_ready;
  assign burst_end = accept & (i_last[gnt_q] | (beat_cnt_q == LAST_CNT));
  assign next_ptr  = (gnt_q == ID_W'(p_num_req - 1)) ? '0 : gnt_q + 1'b1;

  // Granted mux: purely combinational so a beat passes in the same cycle.
  always_comb begin
    o_ready = '0;
    o_valid = 1'b0;
    o_data  = '0;
    if (in_burst) begin
      o_ready[gnt_q] = i_ready;
      o_valid        = i_valid[gnt_q];
      o_data         = i_data[gnt_q];
    end
  end

  assign o_grant    = grant_q;
  assign o_grant_id = in_burst ? gnt_q : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q    <= BURST;
            gnt_q      <= pick_idx;
            grant_q    <= p_num_req'(1) << pick_idx;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
          // Grant drops for one bubble cycle; pointer moves past the winner.
          if (burst_end) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level round-robin model.
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic i_rst_n;
  logic [NREQ-1:0]       i_valid, i_last, o_ready, o_grant;
  logic [NREQ-1:0][31:0] i_data;
  logic                  i_ready, o_valid;
  logic [31:0]           o_data;
  logic [1:0]            o_grant_id;

  logic [1:0]       e_valid, e_last, e_o_ready, e_o_grant;
  logic [1:0][7:0]  e_data;
  logic             e_ready, e_o_valid;
  logic [7:0]       e_o_data;
  logic [0:0]       e_o_grant_id;

  always #5 clk = ~clk;

  bus_arbiter #(.p_width(32), .p_num_req(NREQ), .p_max_burst(MAXB)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_grant(o_grant), .o_grant_id(o_grant_id)
  );

  bus_arbiter #(.p_width(8), .p_num_req(2), .p_max_burst(1)) dut_edge (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(e_valid), .i_data(e_data),
    .i_last(e_last), .o_ready(e_o_ready), .o_valid(e_o_valid), .o_data(e_o_data),
    .i_ready(e_ready), .o_grant(e_o_grant), .o_grant_id(e_o_grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current owner (-1 when idle), next start point, beats taken.
  int m_own, m_ptr, m_cnt;

  int         tr_gid[$];
  bit         tr_acc[$];
  bit         tr_vld[$];
  logic [3:0] tr_rdy[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic trace_clear();
    tr_gid.delete(); tr_acc.delete(); tr_vld.delete(); tr_rdy.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, o_valid, 0);
    check_eq({tag, "_ready"}, o_ready, 0);
    check_eq({tag, "_grant"}, o_grant, 0);
    check_eq({tag, "_gid"}, o_grant_id, 0);
    check_eq({tag, "_data"}, o_data, 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = '0; i_last = '0; i_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) i_data[k] = $urandom;
    e_valid = '0; e_last = '0; e_ready = 1'b0; e_data = '0;
    m_own = -1; m_ptr = 0; m_cnt = 0;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    check_eq("reset_edge_grant", e_o_grant, 0);
    i_rst_n = 1'b1;
    trace_clear();
  endtask

  // One clock of the main DUT: drive, compare against the model mid-cycle,
  // record a trace entry, then advance the model to the next edge.
  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic r);
    logic       ev;
    logic [31:0] ed;
    logic [3:0] er, eg;
    logic [1:0] eid;
    bit         hit;
    int         j;
    i_valid = v; i_last = l; i_ready = r;
    for (int k = 0; k < NREQ; k++) i_data[k] = $urandom;
    #3;
    ev = 1'b0; ed = '0; er = '0; eg = '0; eid = '0;
    if (m_own >= 0) begin
      ev  = v[m_own];
      ed  = i_data[m_own];
      eg  = 4'b0001 << m_own;
      eid = 2'(m_own);
      if (r) er = eg;
    end
    check_eq("o_valid", o_valid, ev);
    check_eq("o_data", o_data, ed);
    check_eq("o_ready", o_ready, er);
    check_eq("o_grant", o_grant, eg);
    check_eq("o_grant_id", o_grant_id, eid);
    tr_gid.push_back((o_grant == '0) ? -1 : int'(o_grant_id));
    tr_acc.push_back(o_valid && i_ready);
    tr_vld.push_back(o_valid);
    tr_rdy.push_back(o_ready);
    if (m_own < 0) begin
      hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!hit && v[j]) begin
          hit = 1'b1; m_own = j; m_cnt = 0;
        end
      end
    end else if (v[m_own] && r) begin
      m_cnt++;
      if (l[m_own] || m_cnt == MAXB) begin
        m_ptr = (m_own + 1) % NREQ;
        m_own = -1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_gid;
    bit exp_acc;
    int beats;
    int g;

    do_reset();

    // Single requester, three beats with last on the third.
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0100, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check_eq("single_lat", tr_gid[0], -1);
    for (int c = 1; c <= 3; c++) check_eq("single_gid", tr_gid[c], 2);
    check_eq("single_idle_after", tr_gid[4], -1);

    // Round robin with continuous requests and no last flags.
    do_reset();
    for (int c = 0; c < 25; c++) cyc(4'b1111, 4'b0000, 1'b1);
    for (int c = 0; c < 25; c++) begin
      exp_gid = (c % 5 == 0) ? -1 : (c / 5) % NREQ;
      check_eq("rr_gid", tr_gid[c], exp_gid);
      check_eq("rr_acc", tr_acc[c], (c % 5) != 0);
    end

    // Backpressure: ready toggles during requester 1's burst.
    do_reset();
    for (int c = 0; c < 10; c++) cyc((c < 8) ? 4'b0010 : 4'b0000, 4'b0000, c[0]);
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      exp_acc = (c >= 1) && (c <= 7) && (c % 2 == 1);
      exp_gid = ((c >= 1) && (c <= 7)) ? 1 : -1;
      check_eq("bp_acc", tr_acc[c], exp_acc);
      check_eq("bp_gid", tr_gid[c], exp_gid);
      if (tr_acc[c]) beats++;
    end
    check_eq("bp_beats", beats, 4);

    // Valid gap on the grantee while requester 3 waits.
    do_reset();
    cyc(4'b0001, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) cyc(4'b1000, 4'b0000, 1'b1);
    cyc(4'b1001, 4'b0001, 1'b1);
    cyc(4'b1000, 4'b0000, 1'b1);
    cyc(4'b1000, 4'b0000, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      check_eq("gap_gid", tr_gid[c], 0);
      check_eq("gap_valid", tr_vld[c], 0);
    end
    for (int c = 0; c <= 6; c++) check_eq("gap_rdy3", tr_rdy[c][3], 0);
    check_eq("gap_idle", tr_gid[6], -1);
    check_eq("gap_next", tr_gid[7], 3);

    // Asynchronous reset in the middle of requester 2's burst.
    do_reset();
    cyc(4'b0010, 4'b0000, 1'b1);
    cyc(4'b0010, 4'b0000, 1'b1);
    cyc(4'b0010, 4'b0010, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b1);
    check_eq("rstmid_pre_gid", tr_gid[5], 2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    m_own = -1; m_ptr = 0; m_cnt = 0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    trace_clear();
    cyc(4'b1111, 4'b0000, 1'b1);
    cyc(4'b1111, 4'b0000, 1'b1);
    check_eq("rstmid_first", tr_gid[1], 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      cyc(4'($urandom) | 4'($urandom), 4'($urandom) & 4'($urandom),
          $urandom_range(0, 3) != 0);
    end

    // Two requesters, single-beat bursts.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      e_valid = 2'b11; e_last = 2'b00; e_ready = 1'b1;
      e_data[0] = 8'($urandom); e_data[1] = 8'($urandom);
      #3;
      if (c % 2 == 0) begin
        check_eq("edge_idle_grant", e_o_grant, 0);
        check_eq("edge_idle_valid", e_o_valid, 0);
        check_eq("edge_idle_data", e_o_data, 0);
      end else begin
        g = ((c - 1) / 2) % 2;
        check_eq("edge_grant", e_o_grant, 2'b01 << g);
        check_eq("edge_gid", e_o_grant_id, g);
        check_eq("edge_valid", e_o_valid, 1);
        check_eq("edge_ready", e_o_ready, 2'b01 << g);
        check_eq("edge_data", e_o_data, e_data[g]);
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
